// File: rtl/rv_p4_pkg.sv
// Shared types for the table update engine.
// Entry layout and command/error codes.
package rv_p4_pkg;

  localparam int TUE_NUM_STAGES = 24;
  localparam int TUE_STAGE_W    = 5;
  localparam int TUE_KEY_W      = 512;
  localparam int TUE_ADDR_W     = 11;
  localparam int TUE_AID_W      = 16;
  localparam int TUE_PARAM_W    = 96;

  typedef enum logic [1:0] {
    CMD_INSERT = 2'd0,
    CMD_DELETE = 2'd1,
    CMD_MODIFY = 2'd2,
    CMD_RSVD   = 2'd3
  } tue_cmd_e;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_STAGE = 2'd1,
    ERR_CMD   = 2'd2
  } tue_err_e;

  typedef struct packed {
    tue_cmd_e                 cmd;
    logic [TUE_STAGE_W-1:0]   stage;
    logic [TUE_ADDR_W-1:0]    addr;
    logic [TUE_KEY_W-1:0]     key;
    logic [TUE_KEY_W-1:0]     mask;
    logic [TUE_AID_W-1:0]     action_id;
    logic [TUE_PARAM_W-1:0]   params;
  } tue_entry_t;

endpackage

// File: rtl/tue_batch_engine_fifo.sv
// Single-clock batch FIFO with flush.
// Power-of-two depth, pointers wrap naturally.
module tue_batch_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full  = (cnt_q == (AW+1)'(DEPTH));
  assign empty = (cnt_q == '0);
  assign level = cnt_q;
  assign rdata = mem_q[rd_q];

  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + AW'(1);
      if (do_pop)  rd_d = rd_q + AW'(1);
      cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata;
  end

endmodule

// File: rtl/tue_batch_engine.sv
// Table update engine: queues MAU updates and
// applies them as one batch after a drain window.
module tue_batch_engine
  import rv_p4_pkg::*;
#(
  parameter int NUM_STAGES   = TUE_NUM_STAGES,
  parameter int KEY_W        = TUE_KEY_W,
  parameter int ADDR_W       = TUE_ADDR_W,
  parameter int PARAM_W      = TUE_PARAM_W,
  parameter int DEPTH        = 16,
  parameter int DRAIN_CYCLES = 32
) (
  input  logic                       clk_dp,
  input  logic                       rst_dp,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [1:0]                 in_cmd,
  input  logic [4:0]                 in_stage,
  input  logic [ADDR_W-1:0]          in_addr,
  input  logic [KEY_W-1:0]           in_key,
  input  logic [KEY_W-1:0]           in_mask,
  input  logic [15:0]                in_action_id,
  input  logic [PARAM_W-1:0]         in_params,
  input  logic                       commit,
  input  logic                       abort,
  output logic [NUM_STAGES-1:0]      tcam_wr_en,
  output logic                       tcam_wr_valid,
  output logic [NUM_STAGES-1:0]      asram_wr_en,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic [KEY_W-1:0]           wr_key,
  output logic [KEY_W-1:0]           wr_mask,
  output logic [32+PARAM_W-1:0]      asram_wr_data,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic [1:0]                 err_code,
  output logic [15:0]                applied_cnt,
  output logic [$clog2(DEPTH):0]     fifo_level
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
  localparam logic [1:0] S_APPLY = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int CNT_W =
    (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;
  localparam int EW = $bits(tue_entry_t);
  localparam logic [NUM_STAGES-1:0] OH1 =
    NUM_STAGES'(1);

  logic [1:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [NUM_STAGES-1:0] tcam_en_q, tcam_en_d;
  logic [NUM_STAGES-1:0] asram_en_q, asram_en_d;
  logic                  tvalid_q, tvalid_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [KEY_W-1:0]      key_q, key_d;
  logic [KEY_W-1:0]      mask_q, mask_d;
  logic [32+PARAM_W-1:0] data_q, data_d;
  logic                  err_q, err_d;
  logic [1:0]            code_q, code_d;
  logic [15:0]           applied_q, applied_d;

  tue_entry_t      in_ent, head, wr_ent;
  logic [EW-1:0]   fifo_rdata;
  logic            fifo_full, fifo_empty;
  logic            push, pop, flush, go_wr, clr;
  logic            bad_stage, bad_cmd;
  logic            is_ins, is_del, is_mod;
  logic [NUM_STAGES-1:0] oh;

  always_comb begin
    in_ent.cmd       = tue_cmd_e'(in_cmd);
    in_ent.stage     = in_stage;
    in_ent.addr      = in_addr;
    in_ent.key       = in_key;
    in_ent.mask      = in_mask;
    in_ent.action_id = in_action_id;
    in_ent.params    = in_params;
  end

  assign head = tue_entry_t'(fifo_rdata);

  tue_batch_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk   (clk_dp),
    .rst   (rst_dp),
    .flush (flush),
    .push  (push),
    .wdata (in_ent),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign in_ready = (state_q == S_IDLE) && !fifo_full;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    flush   = 1'b0;
    push    = in_valid && in_ready;
    pop     = 1'b0;
    go_wr   = 1'b0;
    clr     = 1'b0;
    wr_ent  = head;
    unique case (state_q)
      S_IDLE: begin
        if (abort) begin
          flush = 1'b1;
          push  = 1'b0;
        end else if (commit) begin
          clr = 1'b1;
          if (fifo_empty && !push) begin
            state_d = S_DONE;
          end else if (DRAIN_CYCLES == 0) begin
            // No drain: first write lands right after commit.
            state_d = S_APPLY;
            go_wr   = 1'b1;
            if (fifo_empty) begin
              wr_ent = in_ent;
              push   = 1'b0;
            end else begin
              pop = 1'b1;
            end
          end else begin
            state_d = S_DRAIN;
            cnt_d   = CNT_W'(DRAIN_CYCLES);
          end
        end
      end
      S_DRAIN: begin
        if (abort) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q <= CNT_W'(1)) begin
          state_d = S_APPLY;
          cnt_d   = '0;
          pop     = 1'b1;
          go_wr   = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_APPLY: begin
        if (!fifo_empty) begin
          pop   = 1'b1;
          go_wr = 1'b1;
        end else begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bad_stage = wr_ent.stage >= 5'(NUM_STAGES);
  assign bad_cmd   = !bad_stage && wr_ent.cmd == CMD_RSVD;
  assign is_ins    = !bad_stage && wr_ent.cmd == CMD_INSERT;
  assign is_del    = !bad_stage && wr_ent.cmd == CMD_DELETE;
  assign is_mod    = !bad_stage && wr_ent.cmd == CMD_MODIFY;
  assign oh        = OH1 << wr_ent.stage;

  always_comb begin
    tcam_en_d  = '0;
    asram_en_d = '0;
    err_d      = 1'b0;
    tvalid_d   = tvalid_q;
    addr_d     = addr_q;
    key_d      = key_q;
    mask_d     = mask_q;
    data_d     = data_q;
    code_d     = clr ? ERR_NONE : code_q;
    applied_d  = clr ? 16'd0 : applied_q;
    if (go_wr) begin
      unique case (1'b1)
        bad_stage: begin
          err_d  = 1'b1;
          code_d = ERR_STAGE;
        end
        bad_cmd: begin
          err_d  = 1'b1;
          code_d = ERR_CMD;
        end
        is_ins: begin
          tcam_en_d  = oh;
          asram_en_d = oh;
          tvalid_d   = 1'b1;
        end
        is_del: begin
          tcam_en_d = oh;
          tvalid_d  = 1'b0;
        end
        is_mod: asram_en_d = oh;
        default: ;
      endcase
      if (!err_d) begin
        addr_d = wr_ent.addr;
        key_d  = wr_ent.key;
        mask_d = wr_ent.mask;
        data_d = {wr_ent.action_id, 16'b0,
                  wr_ent.params};
        if (applied_d != 16'hFFFF)
          applied_d = applied_d + 16'd1;
      end
    end
  end

  always_ff @(posedge clk_dp) begin
    if (rst_dp) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      tcam_en_q  <= '0;
      asram_en_q <= '0;
      tvalid_q   <= 1'b0;
      addr_q     <= '0;
      key_q      <= '0;
      mask_q     <= '0;
      data_q     <= '0;
      err_q      <= 1'b0;
      code_q     <= ERR_NONE;
      applied_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tcam_en_q  <= tcam_en_d;
      asram_en_q <= asram_en_d;
      tvalid_q   <= tvalid_d;
      addr_q     <= addr_d;
      key_q      <= key_d;
      mask_q     <= mask_d;
      data_q     <= data_d;
      err_q      <= err_d;
      code_q     <= code_d;
      applied_q  <= applied_d;
    end
  end

  assign tcam_wr_en    = tcam_en_q;
  assign asram_wr_en   = asram_en_q;
  assign tcam_wr_valid = tvalid_q;
  assign wr_addr       = addr_q;
  assign wr_key        = key_q;
  assign wr_mask       = mask_q;
  assign asram_wr_data = data_q;
  assign err           = err_q;
  assign err_code      = code_q;
  assign applied_cnt   = applied_q;
  assign busy          = state_q != S_IDLE;
  assign done          = state_q == S_DONE;

endmodule

// File: tb/tb_tue_batch_engine.sv
// Scoreboard bench for tue_batch_engine.
// Expected writes are queued at push time.
module tb_tue_batch_engine;

  localparam int NS  = 24;
  localparam int DR  = 32;
  localparam int DEP = 16;

  logic         clk_dp = 1'b0;
  logic         rst_dp;
  logic         in_valid, in_ready;
  logic [1:0]   in_cmd;
  logic [4:0]   in_stage;
  logic [10:0]  in_addr;
  logic [511:0] in_key, in_mask;
  logic [15:0]  in_action_id;
  logic [95:0]  in_params;
  logic         commit, abort;
  logic [NS-1:0] tcam_wr_en, asram_wr_en;
  logic         tcam_wr_valid;
  logic [10:0]  wr_addr;
  logic [511:0] wr_key, wr_mask;
  logic [127:0] asram_wr_data;
  logic         busy, done, err;
  logic [1:0]   err_code;
  logic [15:0]  applied_cnt;
  logic [4:0]   fifo_level;

  typedef struct {
    logic [NS-1:0] tcam;
    logic [NS-1:0] asram;
    logic          valid;
    logic          err;
    logic [1:0]    code;
    logic [10:0]   addr;
    logic [511:0]  key;
    logic [511:0]  mask;
    logic [127:0]  data;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  tue_batch_engine #(
    .DEPTH        (DEP),
    .DRAIN_CYCLES (DR)
  ) dut (
    .clk_dp        (clk_dp),
    .rst_dp        (rst_dp),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_cmd        (in_cmd),
    .in_stage      (in_stage),
    .in_addr       (in_addr),
    .in_key        (in_key),
    .in_mask       (in_mask),
    .in_action_id  (in_action_id),
    .in_params     (in_params),
    .commit        (commit),
    .abort         (abort),
    .tcam_wr_en    (tcam_wr_en),
    .tcam_wr_valid (tcam_wr_valid),
    .asram_wr_en   (asram_wr_en),
    .wr_addr       (wr_addr),
    .wr_key        (wr_key),
    .wr_mask       (wr_mask),
    .asram_wr_data (asram_wr_data),
    .busy          (busy),
    .done          (done),
    .err           (err),
    .err_code      (err_code),
    .applied_cnt   (applied_cnt),
    .fifo_level    (fifo_level)
  );

  always #5 clk_dp = ~clk_dp;

  task automatic chk(input string tag,
                     input logic [511:0] got,
                     input logic [511:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic any_wr();
    return (|tcam_wr_en) || (|asram_wr_en) || err;
  endfunction

  always @(negedge clk_dp) begin
    exp_t e;
    if (!rst_dp && any_wr()) begin
      if (sb.size() == 0) begin
        chk("unexpected_wr", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("tcam_en", tcam_wr_en, e.tcam);
        chk("asram_en", asram_wr_en, e.asram);
        chk("err", err, e.err);
        if (e.err) chk("err_code", err_code, e.code);
        if (!e.err) chk("wr_addr", wr_addr, e.addr);
        if (|e.tcam) begin
          chk("wr_valid", tcam_wr_valid, e.valid);
          chk("wr_key", wr_key, e.key);
          chk("wr_mask", wr_mask, e.mask);
        end
        if (|e.asram) chk("wr_data", asram_wr_data, e.data);
      end
    end
  end

  task automatic push(input logic [1:0] cmd,
                      input logic [4:0] st,
                      input logic [10:0] ad,
                      input logic [15:0] aid,
                      input logic [95:0] prm);
    exp_t e;
    logic [511:0] k, m;
    logic [NS-1:0] oh;
    for (int i = 0; i < 16; i++) begin
      k[i*32 +: 32] = $urandom;
      m[i*32 +: 32] = $urandom;
    end
    chk("push_ready", in_ready, 1);
    in_valid = 1'b1; in_cmd = cmd; in_stage = st;
    in_addr = ad; in_key = k; in_mask = m;
    in_action_id = aid; in_params = prm;
    @(posedge clk_dp); #1;
    in_valid = 1'b0;
    oh = '0;
    if (st < NS) oh[st] = 1'b1;
    e.err   = (st >= NS) || (cmd == 2'd3);
    e.code  = (st >= NS) ? 2'd1 : 2'd2;
    e.tcam  = (!e.err && cmd <= 2'd1) ? oh : '0;
    e.asram = (!e.err && cmd != 2'd1) ? oh : '0;
    e.valid = (cmd == 2'd0);
    e.addr  = ad;
    e.key   = k;
    e.mask  = m;
    e.data  = {aid, 16'h0, prm};
    sb.push_back(e);
  endtask

  task automatic run_batch(input int k, input int napp,
                           input int done_off,
                           input int abort_at);
    int off;
    int first;
    bit seen;
    first = -1;
    seen  = 1'b0;
    commit = 1'b1;
    @(posedge clk_dp); #1;
    commit = 1'b0;
    for (off = 0; off < DR + k + 100; off++) begin
      @(negedge clk_dp);
      abort = (off == abort_at);
      if (first < 0 && any_wr()) first = off;
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    abort = 1'b0;
    chk("done_seen", seen, 1);
    if (seen) chk("done_at", off, done_off);
    if (k > 0) chk("first_wr_at", first, DR);
    chk("applied", applied_cnt, napp);
    chk("sb_empty", sb.size(), 0);
    @(negedge clk_dp);
    chk("done_pulse", done, 0);
    chk("busy_after", busy, 0);
  endtask

  initial begin
    int n;
    rst_dp = 1'b1; in_valid = 1'b0; in_cmd = '0;
    in_stage = '0; in_addr = '0; in_key = '0;
    in_mask = '0; in_action_id = '0; in_params = '0;
    commit = 1'b0; abort = 1'b0;
    repeat (3) @(posedge clk_dp);
    #1 rst_dp = 1'b0;
    @(negedge clk_dp);
    chk("rst_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_applied", applied_cnt, 0);
    chk("rst_code", err_code, 0);
    chk("rst_strobes", any_wr() || done, 0);

    push(2'd0, 5'd0, 11'd1, 16'h1111, 96'h1);
    push(2'd0, 5'd5, 11'd2, 16'h2222, 96'h2);
    push(2'd0, 5'd23, 11'd3, 16'h3333, 96'h3);
    chk("level3", fifo_level, 3);
    run_batch(3, 3, DR + 3, -1);

    push(2'd1, 5'd2, 11'd7, 16'h0, 96'h0);
    push(2'd2, 5'd2, 11'd8, 16'hBEEF, 96'hA5);
    run_batch(2, 2, DR + 2, -1);

    for (int i = 0; i < DEP; i++)
      push(2'd0, 5'(i % NS), 11'(i + 100),
           16'(i), 96'(i * 7));
    chk("full_ready", in_ready, 0);
    chk("full_level", fifo_level, DEP);
    in_valid = 1'b1;
    @(posedge clk_dp); #1;
    in_valid = 1'b0;
    chk("full_level2", fifo_level, DEP);
    run_batch(DEP, DEP, DR + DEP, -1);

    push(2'd0, 5'd3, 11'd10, 16'hA, 96'hA);
    push(2'd0, 5'd30, 11'd11, 16'hB, 96'hB);
    push(2'd2, 5'd4, 11'd12, 16'hC, 96'hC);
    run_batch(3, 2, DR + 3, -1);
    chk("code_stage", err_code, 1);

    push(2'd0, 5'd1, 11'd13, 16'hD, 96'hD);
    push(2'd3, 5'd1, 11'd14, 16'hE, 96'hE);
    run_batch(2, 1, DR + 2, -1);
    chk("code_cmd", err_code, 2);

    push(2'd0, 5'd6, 11'd20, 16'h6, 96'h6);
    push(2'd1, 5'd7, 11'd21, 16'h7, 96'h7);
    commit = 1'b1;
    @(posedge clk_dp); #1;
    commit = 1'b0;
    repeat (5) begin
      @(negedge clk_dp);
      chk("drain_quiet", any_wr(), 0);
    end
    chk("drain_ready", in_ready, 0);
    chk("drain_busy", busy, 1);
    abort = 1'b1;
    @(posedge clk_dp); #1;
    abort = 1'b0;
    @(negedge clk_dp);
    chk("abort_busy", busy, 0);
    chk("abort_level", fifo_level, 2);
    repeat (DR + 4) begin
      @(negedge clk_dp);
      chk("abort_quiet", any_wr(), 0);
    end
    run_batch(2, 2, DR + 2, -1);

    push(2'd0, 5'd8, 11'd30, 16'h8, 96'h8);
    push(2'd0, 5'd9, 11'd31, 16'h9, 96'h9);
    push(2'd0, 5'd10, 11'd32, 16'hA, 96'hA);
    run_batch(3, 3, DR + 3, DR + 1);

    push(2'd0, 5'd11, 11'd40, 16'h1, 96'h1);
    push(2'd0, 5'd12, 11'd41, 16'h2, 96'h2);
    abort = 1'b1;
    @(posedge clk_dp); #1;
    abort = 1'b0;
    chk("flush_level", fifo_level, 0);
    sb.delete();

    run_batch(0, 0, 0, -1);
    chk("empty_code", err_code, 0);

    for (int i = 0; i < 4; i++)
      push(2'd0, 5'(i + 14), 11'(i + 50),
           16'(i), 96'(i));
    commit = 1'b1;
    @(posedge clk_dp); #1;
    commit = 1'b0;
    n = 0;
    for (int c = 0; c < DR + 20 && n < 2; c++) begin
      @(negedge clk_dp);
      if (any_wr()) n++;
    end
    chk("rst_mid_seen", n, 2);
    #1 rst_dp = 1'b1;
    sb.delete();
    @(posedge clk_dp); #1;
    rst_dp = 1'b0;
    @(negedge clk_dp);
    chk("rst_mid_strobes", any_wr(), 0);
    chk("rst_mid_level", fifo_level, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_applied", applied_cnt, 0);
    repeat (8) begin
      @(negedge clk_dp);
      chk("rst_mid_quiet", any_wr() || done, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tue_batch_engine.md
Name: tue_batch_engine

Overview:
- Next-generation table update engine in the clk_dp domain: buffers a batch of MAU table updates in a FIFO and applies them atomically after one pipeline-drain window.
- On commit, it drains for DRAIN_CYCLES cycles, then pops one entry per cycle and drives one-hot TCAM/action-SRAM write strobes to the addressed MAU stage.
- Fed by a valid/ready request port from the control-plane bridge; reports done, error and counts.

Parameters:
NUM_STAGES, 24, number of MAU stages driven (one-hot width)
KEY_W, 512, TCAM key/mask width
ADDR_W, 11, TCAM/action-SRAM entry address width
PARAM_W, 96, action parameter width
DEPTH, 16, batch FIFO entries (power of two, >=2)
DRAIN_CYCLES, 32, drain wait in cycles (0 allowed)

Ports:
clk_dp  in  1  datapath clock, sole clock
rst_dp  in  1  synchronous active-high reset
in_valid  in  1  request valid
in_ready  out  1  request accepted when valid&ready
in_cmd  in  2  0=INSERT 1=DELETE 2=MODIFY 3=reserved
in_stage  in  5  target MAU stage
in_addr  in  ADDR_W  entry address
in_key, in_mask  in  KEY_W  TCAM key and mask
in_action_id  in  16  action id
in_params  in  PARAM_W  action params
commit  in  1  pulse: apply queued batch
abort  in  1  pulse: cancel (see rules)
tcam_wr_en  out  NUM_STAGES  one-hot TCAM write strobe
tcam_wr_valid  out  1  entry valid bit to write
asram_wr_en  out  NUM_STAGES  one-hot action-SRAM write strobe
wr_addr  out  ADDR_W  shared address
wr_key, wr_mask  out  KEY_W  shared key/mask
asram_wr_data  out  32+PARAM_W  {action_id,16'b0,params}
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at batch end
err  out  1  one-cycle pulse per rejected entry
err_code  out  2  1=bad stage, 2=reserved cmd; held until next commit
applied_cnt  out  16  entries written in last batch
fifo_level  out  $clog2(DEPTH)+1  queued entries

Behaviour:
- Reset (rst_dp high at a clk_dp edge): state IDLE, FIFO emptied, drain counter cleared; all strobes, done, err, busy 0; err_code 0, applied_cnt 0, in_ready 1. Reset mid-batch discards the remaining entries with no further writes.
- Outputs registered. Data outputs change only on write cycles; strobes 0 otherwise.
- States:
  - IDLE: in_ready = !full. Push on valid&ready. commit -> DRAIN loading counter = DRAIN_CYCLES; clears applied_cnt and err_code. commit with empty FIFO (after any same-cycle push) -> DONE, no drain.
  - DRAIN: in_ready 0. Decrements once per cycle; lasts exactly DRAIN_CYCLES cycles, then APPLY. DRAIN_CYCLES=0 goes to APPLY the cycle after commit.
  - APPLY: pops one entry per cycle and registers outputs. Enters DONE the cycle after the last pop.
  - DONE: done=1 for one cycle, then IDLE.
- Timing: commit in cycle N gives first write strobe in cycle N+1+DRAIN_CYCLES and done in cycle N+1+DRAIN_CYCLES+k, for k entries.
- Per-entry command decode:
  - INSERT: tcam_wr_en[stage]=1, tcam_wr_valid=1, asram_wr_en[stage]=1.
  - DELETE: tcam_wr_en[stage]=1, tcam_wr_valid=0, no asram write.
  - MODIFY: asram_wr_en[stage] only.
  - cmd 3: no strobes, err=1, err_code=2.
  - stage>=NUM_STAGES: no strobes, err=1, err_code=1.
  - A rejected entry still consumes its cycle and does not increment applied_cnt.
- Simultaneous events:
  - Push and commit in the same cycle: the entry is included in the batch.
  - abort in IDLE: flushes the FIFO. abort in DRAIN: returns to IDLE with FIFO kept. abort in APPLY/DONE: ignored, so a batch is atomic once writing begins.
  - abort and commit in the same cycle: abort wins.
  - commit outside IDLE: ignored.
- Full: in_ready 0 when fifo_level==DEPTH. Pointers wrap modulo DEPTH.
- applied_cnt saturates at 16'hFFFF.

Decomposition:
- rv_p4_pkg holds the tue_cmd_e enum (INSERT/DELETE/MODIFY/RSVD), tue_err_e codes, and a tue_entry_t packed struct (cmd, stage, addr, key, mask, action_id, params) parametrised through package constants.
- One sub-module, tue_batch_fifo: synchronous single-clock FIFO with DEPTH entries, push/pop, full/empty/level.
- FSM, decode and output registers stay in the top module.

Test Plan:
- Push 3 INSERTs (stages 0, 5, 23; addrs 1, 2, 3), commit at cycle N, DRAIN_CYCLES=32 -> strobes at N+33..N+35 with the correct one-hot, tcam_wr_valid=1; done at N+36; applied_cnt=3.
- DELETE stage 2 addr 7 then MODIFY stage 2 params=96'hA5 -> first cycle only tcam_wr_en[2] with valid=0; second cycle only asram_wr_en[2], data low bits 'hA5.
- Push DEPTH entries -> in_ready=0 and fifo_level=DEPTH; an extra in_valid is not accepted; commit applies all DEPTH entries in order.
- Entry with stage=30 between two valid entries -> err pulse, err_code=1, no strobes that cycle; applied_cnt=2.
- Commit then abort 5 cycles later -> IDLE, fifo_level unchanged, no strobes. Abort during APPLY -> batch completes, done asserted.
- Commit on empty FIFO -> done the next cycle, applied_cnt=0. rst_dp asserted mid-APPLY -> strobes 0 next cycle, fifo_level=0.
